// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART datapath (TX now, RX later).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // baud_clk cycles per bit period (ratio of baud_clk to baud_clk_16 edges)
  localparam int OVERSAMPLE = 16;

  // Even parity is the XOR of the data bits; odd parity inverts it.
  // Callers zero-extend narrower words, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-register synchronous rising-edge detector. Produces a single-cycle
// pulse on the first baud_clk cycle where d is seen high after being low.
module rise_detect (
  input  logic baud_clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // Remember last cycle's level of d
  always_ff @(posedge baud_clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit serializer: accepts a word on valid/ready and shifts out
// start, LSB-first data, optional parity and 1..2 stop bits, advancing one
// bit per rising edge of baud_clk_16.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 baud_clk_16,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int             BCW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e            state_q,    state_d;
  logic [DATA_BITS-1:0] shreg_q,    shreg_d;
  logic [BCW-1:0]       bit_cnt_q,  bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q,   parity_d;
  logic                 tx_out_q,   tx_out_d;
  logic                 tx_done_q,  tx_done_d;
  logic                 bit_edge;

  rise_detect u_edge (
    .baud_clk (baud_clk),
    .reset    (reset),
    .d        (baud_clk_16),
    .pulse    (bit_edge)
  );

  // Next-state and next-output logic; nothing but the accept moves without a bit edge
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_out_d   = tx_out_q;
    tx_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_out_d = 1'b1;
        if (tx_valid && tx_ready) begin
          shreg_d  = tx_data;
          parity_d = parity_bit(8'(tx_data), PARITY_ODD != 0);
          state_d  = SYNC;
        end
      end
      SYNC: begin
        if (bit_edge) begin
          state_d  = START;
          tx_out_d = 1'b0;
        end
      end
      START: begin
        if (bit_edge) begin
          state_d   = DATA;
          tx_out_d  = shreg_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_edge) begin
          if (bit_cnt_q != BIT_LAST) begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            shreg_d   = shreg_q >> 1;
            tx_out_d  = shreg_q[1];
          end else if (PARITY_EN != 0) begin
            state_d  = PARITY;
            tx_out_d = parity_q;
          end else begin
            state_d    = STOP;
            tx_out_d   = 1'b1;
            stop_cnt_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (bit_edge) begin
          state_d    = STOP;
          tx_out_d   = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_edge) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d   = IDLE;
            tx_done_d = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = 1'b1;
      end
    endcase
  end

  // FSM, datapath and registered outputs; reset aborts any frame in flight
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_out_q   <= tx_out_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_out   = tx_out_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: four instances (8N1, 8E1, 8O1, 8N2) share
// one clock, reset and divider model; frames are checked bit by bit against
// hand-computed line sequences.
module tb_uart_tx_core;
  import uart_pkg::*;

  logic       baud_clk    = 1'b0;
  logic       reset;
  logic       baud_clk_16 = 1'b0;
  logic       freeze      = 1'b0;
  logic [3:0] div_cnt     = '0;

  logic [3:0] vld;
  logic [7:0] tdat [4];
  logic [3:0] txo, rdy, bsy, dn;
  int         done_cnt [4] = '{default: 0};

  int n_tests = 0;
  int n_fail  = 0;
  int base;

  always #5 baud_clk = ~baud_clk;

  // Divider model: free-running /16 counter, MSB is the bit-rate square wave
  always @(negedge baud_clk) begin
    if (!freeze) begin
      div_cnt     = div_cnt + 4'd1;
      baud_clk_16 = div_cnt[3];
    end
  end

  // Count tx_done pulses per instance
  always @(negedge baud_clk) begin
    for (int i = 0; i < 4; i++) if (dn[i] === 1'b1) done_cnt[i]++;
  end

  uart_tx_core u_n1 (
    .baud_clk(baud_clk), .reset(reset), .baud_clk_16(baud_clk_16),
    .tx_data(tdat[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .tx_out(txo[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));

  uart_tx_core #(.PARITY_EN(1), .PARITY_ODD(0)) u_e1 (
    .baud_clk(baud_clk), .reset(reset), .baud_clk_16(baud_clk_16),
    .tx_data(tdat[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .tx_out(txo[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));

  uart_tx_core #(.PARITY_EN(1), .PARITY_ODD(1)) u_o1 (
    .baud_clk(baud_clk), .reset(reset), .baud_clk_16(baud_clk_16),
    .tx_data(tdat[2]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
    .tx_out(txo[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));

  uart_tx_core #(.STOP_BITS(2)) u_n2 (
    .baud_clk(baud_clk), .reset(reset), .baud_clk_16(baud_clk_16),
    .tx_data(tdat[3]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
    .tx_out(txo[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge baud_clk);
    #1;
  endtask

  // Line must sit at val (and the core stay busy) for ncyc consecutive cycles
  task automatic hold_check(input int d, input logic val, input int ncyc, input string tag);
    int bad = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (txo[d] !== val || bsy[d] !== 1'b1) bad++;
      step();
    end
    check(tag, bad, 0);
  endtask

  // exp[i] is the line level of bit period i (0 = start bit)
  task automatic check_bits(input int d, input logic [15:0] exp, input int lo, input int hi,
                            input string tag);
    for (int i = lo; i <= hi; i++)
      hold_check(d, exp[i], OVERSAMPLE, $sformatf("%s_bit%0d", tag, i));
  endtask

  task automatic send(input int d, input logic [7:0] data, input logic hold);
    tdat[d] = data;
    vld[d]  = 1'b1;
    step();
    if (!hold) vld[d] = 1'b0;
  endtask

  // Bounded wait for the start bit; latency in cycles must be within [lo, hi]
  task automatic wait_start(input int d, input int lo, input int hi, input string tag);
    int n = 0;
    while (txo[d] !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    check($sformatf("%s_start_lat%0d", tag, n), (n >= lo && n <= hi), 1);
  endtask

  // Called right after the final stop bit: done pulse, ready back, single pulse
  task automatic end_frame(input int d, input int base_cnt, input string tag);
    check({tag, "_done"},  dn[d],  1'b1);
    check({tag, "_ready"}, rdy[d], 1'b1);
    check({tag, "_idle"},  bsy[d], 1'b0);
    check({tag, "_line"},  txo[d], 1'b1);
    step();
    check({tag, "_done_clr"}, dn[d], 1'b0);
    check({tag, "_done_cnt"}, done_cnt[d] - base_cnt, 1);
  endtask

  initial begin
    reset = 1'b1;
    vld   = '0;
    for (int i = 0; i < 4; i++) tdat[i] = 8'h00;
    repeat (3) step();

    // Reset state of every instance
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst%0d_tx_out", i), txo[i], 1'b1);
      check($sformatf("rst%0d_ready", i),  rdy[i], 1'b1);
      check($sformatf("rst%0d_busy", i),   bsy[i], 1'b0);
      check($sformatf("rst%0d_done", i),   dn[i],  1'b0);
    end
    reset = 1'b0;
    step();

    // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1
    base = done_cnt[0];
    send(0, 8'hA5, 1'b0);
    check("a5_busy_after_accept",  bsy[0], 1'b1);
    check("a5_ready_after_accept", rdy[0], 1'b0);
    wait_start(0, 1, 17, "a5");
    check_bits(0, 16'h034A, 0, 9, "a5");
    end_frame(0, base, "a5");

    // 8E1, 0x07: parity bit 1, 11 bit periods
    base = done_cnt[1];
    send(1, 8'h07, 1'b0);
    wait_start(1, 1, 17, "e07");
    check_bits(1, 16'h060E, 0, 10, "e07");
    end_frame(1, base, "e07");

    // 8O1, 0x07: parity bit 0; divider frozen for 100 cycles inside bit 4
    base = done_cnt[2];
    send(2, 8'h07, 1'b0);
    wait_start(2, 1, 17, "o07");
    check_bits(2, 16'h040E, 0, 3, "o07");
    hold_check(2, 1'b0, 5, "o07_bit4_pre");
    freeze = 1'b1;
    hold_check(2, 1'b0, 100, "o07_frozen");
    freeze = 1'b0;
    hold_check(2, 1'b0, 11, "o07_bit4_post");
    check_bits(2, 16'h040E, 5, 10, "o07");
    end_frame(2, base, "o07");

    // 8N2, 0x00 twice with tx_valid held: 32 cycles of stop, then next frame
    base = done_cnt[3];
    send(3, 8'h00, 1'b1);
    wait_start(3, 1, 17, "n2a");
    check_bits(3, 16'h0600, 0, 10, "n2a");
    end_frame(3, base, "n2a");
    check("n2b_accepted", bsy[3], 1'b1);
    vld[3] = 1'b0;
    base = done_cnt[3];
    wait_start(3, 15, 15, "n2b");
    check_bits(3, 16'h0600, 0, 10, "n2b");
    end_frame(3, base, "n2b");

    // 8N1, 0xC3 in flight; 0x3C offered and tx_data changed while busy
    base = done_cnt[0];
    send(0, 8'hC3, 1'b0);
    wait_start(0, 1, 17, "c3");
    check_bits(0, 16'h0386, 0, 2, "c3");
    tdat[0] = 8'h3C;
    vld[0]  = 1'b1;
    check("c3_ready_while_busy", rdy[0], 1'b0);
    check_bits(0, 16'h0386, 3, 3, "c3");
    vld[0] = 1'b0;
    check_bits(0, 16'h0386, 4, 9, "c3");
    end_frame(0, base, "c3");
    begin
      int bad = 0;
      for (int k = 0; k < 40; k++) begin
        if (txo[0] !== 1'b1 || bsy[0] !== 1'b0) bad++;
        step();
      end
      check("c3_no_second_frame", bad, 0);
    end

    // 8N1, 0x00 aborted by reset during data bit 4
    base = done_cnt[0];
    send(0, 8'h00, 1'b0);
    wait_start(0, 1, 17, "rst");
    check_bits(0, 16'h0200, 0, 4, "rst");
    hold_check(0, 1'b0, 3, "rst_bit5_pre");
    reset = 1'b1;
    step();
    check("rst_mid_tx_out", txo[0], 1'b1);
    check("rst_mid_ready",  rdy[0], 1'b1);
    check("rst_mid_busy",   bsy[0], 1'b0);
    check("rst_mid_done",   dn[0],  1'b0);
    reset = 1'b0;
    repeat (20) step();
    check("rst_no_done", done_cnt[0] - base, 0);
    check("rst_line_idle", txo[0], 1'b1);

    // 8N1, 0x55 after the abort
    base = done_cnt[0];
    send(0, 8'h55, 1'b0);
    wait_start(0, 1, 17, "x55");
    check_bits(0, 16'h02AA, 0, 9, "x55");
    end_frame(0, base, "x55");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
